aftab_pipe_shifter: RTL

//  Parametrised, pipelined barrel shift unit for the AFTAB datapath; successor to the combinational BSU.

---
 rtl/aftab_pipe_shifter_pkg.sv | 31 +++
 rtl/aftab_pipe_shifter_shift_level.sv | 31 +++
 rtl/aftab_pipe_shifter.sv | 119 +++++++++++
 3 files changed

// File: rtl/aftab_pipe_shifter_pkg.sv
// Shared definitions for the pipelined barrel shift unit: mode encodings
// (also used by the decoder/controller) and helpers that split the mux
// levels across pipeline stages.
package aftab_pipe_shifter_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shiftMode_e;

  // Number of mux levels owned by stage s; the first (levels mod stages)
  // stages each take one extra level.
  function automatic int unsigned levelCount(input int unsigned levels,
                                             input int unsigned stages,
                                             input int unsigned s);
    return (levels / stages) + ((s < (levels % stages)) ? 1 : 0);
  endfunction

  // Index of the first mux level owned by stage s.
  function automatic int unsigned levelStart(input int unsigned levels,
                                             input int unsigned stages,
                                             input int unsigned s);
    int unsigned extra;
    extra = levels % stages;
    return s * (levels / stages) + ((s < extra) ? s : extra);
  endfunction

endpackage

// File: rtl/aftab_pipe_shifter_shift_level.sv
// One combinational mux level of the barrel shifter: shifts or rotates by
// the fixed distance DIST when en is set, otherwise passes data through.
module aftab_shift_level
  import aftab_pipe_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] shifted
);

  // Select the shifted/rotated form for this level's distance.
  always_comb begin
    shifted = data;
    if (en) begin
      case (mode)
        SHIFT_SLL: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHIFT_SRL: shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        SHIFT_SRA: shifted = {{DIST{fill_bit}}, data[WIDTH-1:DIST]};
        SHIFT_ROL: shifted = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
        SHIFT_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
        default:   shifted = data;
      endcase
    end
  end

endmodule

// File: rtl/aftab_pipe_shifter.sv
// Pipelined barrel shift unit for the AFTAB datapath. The log2(WIDTH) mux
// levels are distributed over PIPE_STAGES register stages; the last stage
// register drives the output. Valid/ready handshake with whole-pipe stall
// and an in-flight flush.
module aftab_pipe_shifter
  import aftab_pipe_shifter_pkg::*;
#(
  parameter  int unsigned WIDTH       = 32,
  parameter  int unsigned PIPE_STAGES = 2,
  localparam int unsigned SHAMT_W     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 ||
      PIPE_STAGES < 1 || PIPE_STAGES > SHAMT_W) begin : gBadParam
    $error("aftab_pipe_shifter: unsupported WIDTH/PIPE_STAGES combination");
  end

  logic                   stall;
  logic [PIPE_STAGES-1:0] stgValid;

  // Stage boundaries: index s is what stage s consumes; data index
  // PIPE_STAGES is the output register.
  logic [WIDTH-1:0]   bndData  [PIPE_STAGES+1];
  logic [SHAMT_W-1:0] bndShamt [PIPE_STAGES];
  logic [2:0]         bndMode  [PIPE_STAGES];
  logic               bndFill  [PIPE_STAGES];

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = stgValid[PIPE_STAGES-1];
  assign out_data  = bndData[PIPE_STAGES];

  // SRA fill bit is the operand MSB captured at entry and carried along.
  assign bndData[0]  = in_data;
  assign bndShamt[0] = in_shamt;
  assign bndMode[0]  = in_mode;
  assign bndFill[0]  = in_data[WIDTH-1];

  // Valid pipeline: reset beats flush, flush beats stall; bubbles advance as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      stgValid <= '0;
    end else if (flush) begin
      stgValid <= '0;
    end else if (!stall) begin
      stgValid[0] <= in_valid;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        stgValid[i] <= stgValid[i-1];
      end
    end
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : gStage
    localparam int unsigned LN = levelCount(SHAMT_W, PIPE_STAGES, s);
    localparam int unsigned LS = levelStart(SHAMT_W, PIPE_STAGES, s);

    logic [WIDTH-1:0] chain [LN+1];
    logic [WIDTH-1:0] dataQ;

    assign chain[0] = bndData[s];

    for (genvar j = 0; j < LN; j++) begin : gLevel
      aftab_shift_level #(
        .WIDTH(WIDTH),
        .DIST (1 << (LS + j))
      ) uLevel (
        .data    (chain[j]),
        .en      (bndShamt[s][LS+j]),
        .mode    (bndMode[s]),
        .fill_bit(bndFill[s]),
        .shifted (chain[j+1])
      );
    end

    if (s == PIPE_STAGES - 1) begin : gOut
      // Output register: the only data register with a reset value.
      always_ff @(posedge clk) begin
        if (rst) begin
          dataQ <= '0;
        end else if (!stall) begin
          dataQ <= chain[LN];
        end
      end
    end else begin : gMid
      logic [SHAMT_W-1:0] shamtQ;
      logic [2:0]         modeQ;
      logic               fillQ;

      // Intermediate stage: partial result plus control carried forward.
      always_ff @(posedge clk) begin
        if (!stall) begin
          dataQ  <= chain[LN];
          shamtQ <= bndShamt[s];
          modeQ  <= bndMode[s];
          fillQ  <= bndFill[s];
        end
      end

      assign bndShamt[s+1] = shamtQ;
      assign bndMode[s+1]  = modeQ;
      assign bndFill[s+1]  = fillQ;
    end

    assign bndData[s+1] = dataQ;
  end

endmodule
